led_effect_sched: RTL and testbench

// Schedules the watch's LED/display effects onto one shared Flash instance and one

---
 rtl/led_effect_sched.sv | 144 ++++++++++++++
 tb/tb_led_effect_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_effect_sched.sv
// Picks one LED/display effect from watch status (alarm > edit > chime > idle),
// drives the shared Flash/BreathLED generators and muxes their pwm onto the outputs.
module led_effect_sched #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int LEDS         = 8,
  parameter int ALARM_SEC    = 60,
  parameter int CHIME_SEC    = 3,
  parameter int IDLE_BREATHE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alarm_trig,
  input  logic            alarm_ack,
  input  logic            chime_req,
  input  logic            edit_active,
  input  logic [1:0]      edit_field,
  input  logic            flash_pwm,
  input  logic            breath_pwm,
  output logic            flash_en,
  output logic            flash_rst,
  output logic            breath_en,
  output logic            breath_rst,
  output logic [LEDS-1:0] led,
  output logic [3:0]      digit_blank,
  output logic [1:0]      fx_state
);
  // state | meaning
  // IDLE  | no event; LEDs breathe (or stay dark)
  // CHIME | top-of-hour flash for CHIME_SEC seconds
  // EDIT  | time edit; the edited digit pair blinks
  // ALARM | alarm flash until acknowledged or ALARM_SEC timeout
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHIME = 2'd1,
    S_EDIT  = 2'd2,
    S_ALARM = 2'd3
  } fx_t;

  localparam int              CYC_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_HZ - 1);
  localparam logic [7:0]      ALARM_LIM = 8'(ALARM_SEC);
  localparam logic [7:0]      CHIME_LIM = 8'(CHIME_SEC);
  localparam logic            BREATHE   = (IDLE_BREATHE != 0);

  fx_t              state;
  fx_t              nxt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [7:0]       sec_cnt;
  logic [7:0]       sec_inc;
  logic [1:0]       field_q;
  logic             sec_tick;
  logic             alarm_to;
  logic             chime_to;
  logic             enter;
  logic             restart;
  logic [LEDS-1:0]  led_d;
  logic [3:0]       blank_d;

  assign sec_tick = (cyc_cnt == CYC_LAST);
  assign sec_inc  = (sec_cnt == 8'hFF) ? sec_cnt : sec_cnt + 8'd1;

  // A limit is hit on the edge where the seconds counter reaches it, so an
  // effect lasts exactly N * CLK_HZ cycles from its entry.
  assign alarm_to = sec_tick && (sec_inc == ALARM_LIM);
  assign chime_to = sec_tick && (sec_inc == CHIME_LIM);

  always_comb begin
    nxt = state;
    if (alarm_trig) begin
      nxt = S_ALARM;
    end else begin
      case (state)
        S_ALARM: if (alarm_ack || alarm_to) nxt = edit_active ? S_EDIT : S_IDLE;
        S_IDLE: begin
          if (edit_active)    nxt = S_EDIT;
          else if (chime_req) nxt = S_CHIME;
        end
        S_CHIME: begin
          if (edit_active)   nxt = S_EDIT;
          else if (chime_to) nxt = S_IDLE;
        end
        S_EDIT:  if (!edit_active) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  assign enter   = alarm_trig || (nxt != state);
  assign restart = enter || ((state == S_EDIT) && (edit_field != field_q));

  // Output mux follows the state being entered so led/blank line up with fx_state.
  always_comb begin
    led_d   = '0;
    blank_d = 4'b0000;
    case (nxt)
      S_IDLE:  led_d = {LEDS{breath_pwm & BREATHE}};
      S_CHIME: led_d = {LEDS{flash_pwm}};
      S_EDIT:  blank_d = (4'b0001 << edit_field) & {4{~flash_pwm}};
      S_ALARM: begin
        for (int i = 0; i < LEDS; i++) begin
          led_d[i] = i[0] ? ~flash_pwm : flash_pwm;
        end
        blank_d = {4{~flash_pwm}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cyc_cnt     <= '0;
      sec_cnt     <= '0;
      field_q     <= '0;
      flash_en    <= 1'b0;
      flash_rst   <= 1'b0;
      breath_en   <= 1'b0;
      breath_rst  <= 1'b0;
      led         <= '0;
      digit_blank <= '0;
    end else begin
      state   <= nxt;
      field_q <= edit_field;
      if (enter) begin
        cyc_cnt <= '0;
        sec_cnt <= '0;
      end else if (sec_tick) begin
        cyc_cnt <= '0;
        sec_cnt <= sec_inc;
      end else begin
        cyc_cnt <= cyc_cnt + CYC_W'(1);
      end
      flash_rst   <= restart;
      breath_rst  <= restart;
      flash_en    <= (nxt != S_IDLE);
      breath_en   <= (nxt == S_IDLE);
      led         <= led_d;
      digit_blank <= blank_d;
    end
  end

  assign fx_state = state;

endmodule

// File: tb/tb_led_effect_sched.sv
// Bench for led_effect_sched: small Flash/BreathLED models plus a cycle
// scoreboard fed by a reference model of the effect scheduler.
module tb_led_effect_sched;
  localparam int CLK_HZ = 10, LEDS = 8, ALARM_SEC = 4, CHIME_SEC = 2;

  logic clk = 1'b0;
  logic reset = 1'b0, alarm_trig = 1'b0, alarm_ack = 1'b0, chime_req = 1'b0, edit_active = 1'b0;
  logic [1:0] edit_field = 2'd0;
  logic flash_pwm, breath_pwm, flash_en, flash_rst, breath_en, breath_rst;
  logic [LEDS-1:0] led;
  logic [3:0] digit_blank;
  logic [1:0] fx_state;

  always #5 clk = ~clk;

  led_effect_sched #(
    .CLK_HZ(CLK_HZ), .LEDS(LEDS), .ALARM_SEC(ALARM_SEC), .CHIME_SEC(CHIME_SEC), .IDLE_BREATHE(1)
  ) dut (
    .clk(clk), .reset(reset), .alarm_trig(alarm_trig), .alarm_ack(alarm_ack),
    .chime_req(chime_req), .edit_active(edit_active), .edit_field(edit_field),
    .flash_pwm(flash_pwm), .breath_pwm(breath_pwm), .flash_en(flash_en),
    .flash_rst(flash_rst), .breath_en(breath_en), .breath_rst(breath_rst),
    .led(led), .digit_blank(digit_blank), .fx_state(fx_state)
  );

  // Generator models: flash is a 4-cycle square wave, breath a 5/8 duty wave.
  logic [1:0] fl_cnt = 2'd0;
  logic [2:0] br_cnt = 3'd0;
  always @(posedge clk) begin
    fl_cnt <= (flash_rst || !flash_en) ? 2'd0 : fl_cnt + 2'd1;
    br_cnt <= (breath_rst || !breath_en) ? 3'd0 : br_cnt + 3'd1;
  end
  assign flash_pwm  = flash_en & fl_cnt[1];
  assign breath_pwm = breath_en & (br_cnt < 3'd5);

  typedef struct packed {
    logic [1:0]      st;
    logic            frst;
    logic            brst;
    logic            fen;
    logic            ben;
    logic [LEDS-1:0] led;
    logic [3:0]      blank;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic [17:0] obs;
  assign obs = {fx_state, flash_rst, breath_rst, flash_en, breath_en, led, digit_blank};

  logic [1:0] m_st = 2'd0;
  int         m_age = 0;
  logic [1:0] m_fld = 2'd0;

  // Drives one cycle of inputs, predicts the registered outputs, queues them.
  task automatic drive(input logic rn, input logic at, input logic ack, input logic chr,
                       input logic ed, input logic [1:0] fld);
    exp_t e;
    logic [1:0] nx;
    logic rs;
    @(negedge clk);
    reset = rn; alarm_trig = at; alarm_ack = ack; chime_req = chr;
    edit_active = ed; edit_field = fld;
    e = '0;
    if (!rn) begin
      m_st = 2'd0; m_age = 0; m_fld = 2'd0;
    end else begin
      nx = m_st;
      if (at) nx = 2'd3;
      else begin
        case (m_st)
          2'd3: if (ack || (m_age + 1 == ALARM_SEC * CLK_HZ)) nx = ed ? 2'd2 : 2'd0;
          2'd0: if (ed) nx = 2'd2; else if (chr) nx = 2'd1;
          2'd1: if (ed) nx = 2'd2; else if (m_age + 1 == CHIME_SEC * CLK_HZ) nx = 2'd0;
          default: if (!ed) nx = 2'd0;
        endcase
      end
      rs = at || (nx != m_st) || ((nx == 2'd2) && (fld != m_fld));
      m_age = (at || (nx != m_st)) ? 0 : m_age + 1;
      m_st = nx;
      m_fld = fld;
      e.st = nx; e.frst = rs; e.brst = rs;
      e.fen = (nx != 2'd0); e.ben = (nx == 2'd0);
      case (nx)
        2'd0: e.led = {LEDS{breath_pwm}};
        2'd1: e.led = {LEDS{flash_pwm}};
        2'd2: e.blank = flash_pwm ? 4'b0000 : (4'b0001 << fld);
        default: begin
          e.led   = {LEDS/2{~flash_pwm, flash_pwm}};
          e.blank = {4{~flash_pwm}};
        end
      endcase
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL reset_hold: got %h want %h", obs, e); end
    end
    drive(1'b1, 0, 0, 0, 0, 2'd0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_release: got %h want %h", obs, e); end
    n_cmp++;
    if (breath_en !== 1'b1) begin n_bad++; $display("FAIL reset_breath_en: got %b want 1", breath_en); end
    repeat (6) begin
      drive(1'b1, 0, 0, 0, 0, 2'd0);
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL idle_breathe: got %h want %h", obs, e); end
    end
  endtask

  task automatic test_chime();
    exp_t e;
    int cyc;
    bit done, saw_hi;
    drive(1'b1, 0, 0, 1, 0, 2'd0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL chime_entry: got %h want %h", obs, e); end
    n_cmp++;
    if (fx_state !== 2'd1 || flash_rst !== 1'b1)
      begin n_bad++; $display("FAIL chime_pulse: got st=%0d rst=%b want st=1 rst=1", fx_state, flash_rst); end
    cyc = 0; done = 0; saw_hi = 0;
    while (!done && cyc < 40) begin
      drive(1'b1, 0, 0, 0, 0, 2'd0);
      cyc++;
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL chime_run: got %h want %h", obs, e); end
      if (fx_state == 2'd1 && led == 8'hFF) saw_hi = 1;
      if (fx_state != 2'd1) done = 1;
    end
    n_cmp++;
    if (!done || cyc != 20) begin n_bad++; $display("FAIL chime_duration: got %0d cycles want 20", cyc); end
    n_cmp++;
    if (!saw_hi) begin n_bad++; $display("FAIL chime_led: got no lit cycle want led=ff"); end
  endtask

  task automatic test_edit();
    exp_t e;
    bit saw_b, saw_z, saw_old;
    drive(1'b1, 0, 0, 0, 1, 2'd2);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL edit_entry: got %h want %h", obs, e); end
    n_cmp++;
    if (fx_state !== 2'd2 || flash_rst !== 1'b1)
      begin n_bad++; $display("FAIL edit_pulse: got st=%0d rst=%b want st=2 rst=1", fx_state, flash_rst); end
    saw_b = 0; saw_z = 0;
    repeat (8) begin
      drive(1'b1, 0, 0, 0, 1, 2'd2);
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL edit_run: got %h want %h", obs, e); end
      if (digit_blank == 4'b0100) saw_b = 1;
      if (digit_blank == 4'b0000) saw_z = 1;
    end
    n_cmp++;
    if (!(saw_b && saw_z)) begin n_bad++; $display("FAIL edit_blink: got b=%b z=%b want 1 1", saw_b, saw_z); end
    drive(1'b1, 0, 0, 0, 1, 2'd1);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL edit_field_chg: got %h want %h", obs, e); end
    n_cmp++;
    if (fx_state !== 2'd2 || flash_rst !== 1'b1)
      begin n_bad++; $display("FAIL edit_field_pulse: got st=%0d rst=%b want st=2 rst=1", fx_state, flash_rst); end
    saw_b = 0; saw_old = 0;
    repeat (8) begin
      drive(1'b1, 0, 0, 0, 1, 2'd1);
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL edit_run2: got %h want %h", obs, e); end
      if (digit_blank == 4'b0010) saw_b = 1;
      if (digit_blank == 4'b0100) saw_old = 1;
    end
    n_cmp++;
    if (!saw_b || saw_old) begin n_bad++; $display("FAIL edit_blank_move: got new=%b old=%b want 1 0", saw_b, saw_old); end
  endtask

  task automatic test_alarm_retrigger();
    exp_t e;
    int k;
    bit done;
    drive(1'b1, 1, 0, 0, 1, 2'd1);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL alarm_entry: got %h want %h", obs, e); end
    k = 0; done = 0;
    while (!done && k < 100) begin
      k++;
      drive(1'b1, k == 30, 0, 0, 1, 2'd1);
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL alarm_run: got %h want %h at %0d", obs, e, k); end
      if (k == 30) begin
        n_cmp++;
        if (fx_state !== 2'd3 || flash_rst !== 1'b1)
          begin n_bad++; $display("FAIL alarm_retrig: got st=%0d rst=%b want st=3 rst=1", fx_state, flash_rst); end
      end
      if (fx_state != 2'd3) done = 1;
    end
    n_cmp++;
    if (!done || k != 70 || fx_state !== 2'd2)
      begin n_bad++; $display("FAIL alarm_timeout: got %0d cycles st=%0d want 70 st=2", k, fx_state); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive(1'b1, 0, 0, 0, 0, 2'd1);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL edit_exit: got %h want %h", obs, e); end
    drive(1'b1, 1, 0, 0, 0, 2'd0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL b2b_alarm: got %h want %h", obs, e); end
    drive(1'b1, 1, 1, 0, 0, 2'd0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL b2b_trig_ack: got %h want %h", obs, e); end
    n_cmp++;
    if (fx_state !== 2'd3 || flash_rst !== 1'b1)
      begin n_bad++; $display("FAIL trig_beats_ack: got st=%0d rst=%b want st=3 rst=1", fx_state, flash_rst); end
    drive(1'b1, 0, 1, 0, 0, 2'd0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL b2b_ack: got %h want %h", obs, e); end
    n_cmp++;
    if (fx_state !== 2'd0) begin n_bad++; $display("FAIL ack_exit: got st=%0d want 0", fx_state); end
  endtask

  task automatic test_chime_drop();
    exp_t e;
    bit saw_chime;
    drive(1'b1, 1, 0, 0, 0, 2'd0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL drop_alarm: got %h want %h", obs, e); end
    drive(1'b1, 0, 0, 1, 0, 2'd0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL drop_req: got %h want %h", obs, e); end
    repeat (3) begin
      drive(1'b1, 0, 0, 0, 0, 2'd0);
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL drop_hold: got %h want %h", obs, e); end
    end
    drive(1'b1, 0, 1, 0, 0, 2'd0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL drop_ack: got %h want %h", obs, e); end
    saw_chime = 0;
    repeat (5) begin
      drive(1'b1, 0, 0, 0, 0, 2'd0);
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL drop_after: got %h want %h", obs, e); end
      if (fx_state == 2'd1) saw_chime = 1;
    end
    n_cmp++;
    if (saw_chime) begin n_bad++; $display("FAIL chime_not_dropped: got st=1 want no chime"); end
    drive(1'b1, 1, 0, 0, 0, 2'd0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL mid_alarm_entry: got %h want %h", obs, e); end
    repeat (5) begin
      drive(1'b1, 0, 0, 0, 0, 2'd0);
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL mid_alarm_run: got %h want %h", obs, e); end
    end
    drive(1'b0, 0, 0, 0, 0, 2'd0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== 18'd0) begin n_bad++; $display("FAIL mid_alarm_reset: got %h want 0", obs); end
    drive(1'b1, 0, 0, 0, 0, 2'd0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL post_reset: got %h want %h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_chime();
    test_edit();
    test_alarm_retrigger();
    test_back_to_back();
    test_chime_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
